// File: rtl/am_dc_injector.sv
// am_dc_injector: measures message peak, derives DC = peak/m with a
// sequential restoring divider, and outputs the saturated envelope msg + dc.
module am_dc_injector #(
    parameter int IO_width  = 14,
    parameter int CNT_WIDTH = 32,
    parameter int CNT_NUM   = 3600,
    parameter int DEPTH_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       meas_trig,
    input  logic                       cal_trig,
    input  logic [DEPTH_W-1:0]         depth,
    input  logic signed [IO_width-1:0] msg,
    output logic signed [IO_width-1:0] env,
    output logic signed [IO_width-1:0] dc,
    output logic                       busy,
    output logic                       dc_valid
);

    localparam int MAG_W = IO_width - 1;
    localparam int NUM_W = MAG_W + DEPTH_W;
    localparam int IT_W  = $clog2(NUM_W + 1);

    localparam logic [MAG_W-1:0]     MAG_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CNT_NUM - 1);
    localparam logic [IT_W-1:0]      IT_LAST  = IT_W'(NUM_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MEAS = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    logic [1:0]                 state;
    logic signed [IO_width-1:0] msg_r;
    logic [MAG_W-1:0]           peak;
    logic                       peak_valid;
    logic [CNT_WIDTH-1:0]       cnt;

    logic [DEPTH_W-1:0]         div_r;
    logic [NUM_W-1:0]           quo;
    logic [DEPTH_W:0]           rem;
    logic [IT_W-1:0]            it;

    logic [MAG_W-1:0]           mag;
    logic [IO_width:0]          sum;
    logic signed [IO_width-1:0] env_nx;
    logic [DEPTH_W:0]           rem_sh;
    logic [DEPTH_W:0]           rem_sub;
    logic                       ge;

    assign busy = (state != S_IDLE);

    // Magnitude of the registered sample; the most negative code saturates.
    always_comb begin
        mag = msg_r[MAG_W-1:0];
        if (msg_r[IO_width-1]) begin
            if (msg_r[MAG_W-1:0] == '0)
                mag = MAG_MAX;
            else
                mag = ~msg_r[MAG_W-1:0] + MAG_W'(1);
        end
    end

    // Envelope sum with one guard bit, clamped to the signed output range.
    always_comb begin
        sum    = {dc[IO_width-1], dc} + {msg_r[IO_width-1], msg_r};
        env_nx = sum[IO_width-1:0];
        if (sum[IO_width] != sum[IO_width-1])
            env_nx = sum[IO_width] ? {1'b1, {MAG_W{1'b0}}}
                                   : {1'b0, MAG_MAX};
    end

    // One restoring-division step: shift in the next numerator bit and
    // subtract the divisor when it fits. The remainder's top bit can only
    // be set when dividing by zero, where it forces a one into the quotient.
    always_comb begin
        rem_sh  = {rem[DEPTH_W-1:0], quo[NUM_W-1]};
        ge      = rem[DEPTH_W] | (rem_sh >= {1'b0, div_r});
        rem_sub = rem_sh - {1'b0, div_r};
    end

    // Sample pipeline: register the message, then the saturated envelope.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_r <= '0;
            env   <= '0;
        end else begin
            msg_r <= msg;
            env   <= env_nx;
        end
    end

    // Control FSM: peak measurement window and sequential DC divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            peak       <= '0;
            peak_valid <= 1'b0;
            cnt        <= '0;
            div_r      <= '0;
            quo        <= '0;
            rem        <= '0;
            it         <= '0;
            dc         <= '0;
            dc_valid   <= 1'b0;
        end else begin
            dc_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (meas_trig) begin
                        state      <= S_MEAS;
                        peak       <= '0;
                        peak_valid <= 1'b0;
                        cnt        <= '0;
                    end else if (cal_trig && peak_valid) begin
                        state <= S_DIV;
                        div_r <= depth;
                        quo   <= {peak, {DEPTH_W{1'b0}}};
                        rem   <= '0;
                        it    <= '0;
                    end
                end
                S_MEAS: begin
                    if (mag > peak)
                        peak <= mag;
                    cnt <= cnt + CNT_WIDTH'(1);
                    if (cnt == CNT_LAST) begin
                        peak_valid <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                S_DIV: begin
                    if (it != IT_LAST) begin
                        rem <= ge ? rem_sub : rem_sh;
                        quo <= {quo[NUM_W-2:0], ge};
                        it  <= it + IT_W'(1);
                    end else begin
                        if ((div_r == '0) || (|quo[NUM_W-1:MAG_W]))
                            dc <= {1'b0, MAG_MAX};
                        else
                            dc <= {1'b0, quo[MAG_W-1:0]};
                        dc_valid <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_am_dc_injector.sv
// tb_am_dc_injector: scenario tasks with scoreboard queues for the
// envelope pipeline and for DC results of each calibration.
module tb_am_dc_injector;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              meas_trig = 1'b0;
    logic              cal_trig = 1'b0;
    logic [7:0]        depth = '0;
    logic signed [13:0] msg = '0;
    logic signed [13:0] env;
    logic signed [13:0] dc;
    logic              busy;
    logic              dc_valid;

    int checks = 0;
    int errors = 0;
    int model_dc = 0;
    int model_peak = 0;
    int env_q[$];
    int dc_q[$];

    am_dc_injector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .meas_trig (meas_trig),
        .cal_trig  (cal_trig),
        .depth     (depth),
        .msg       (msg),
        .env       (env),
        .dc        (dc),
        .busy      (busy),
        .dc_valid  (dc_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    function automatic int sat14(input int v);
        if (v > 8191) return 8191;
        if (v < -8192) return -8192;
        return v;
    endfunction

    function automatic int abs_sat(input int v);
        if (v >= 0) return v;
        if (-v > 8191) return 8191;
        return -v;
    endfunction

    function automatic int div_model(input int p, input int d);
        int q;
        if (d == 0) return 8191;
        q = (p * 256) / d;
        return (q > 8191) ? 8191 : q;
    endfunction

    function automatic int pattern(input int mode, input int i);
        case (mode)
            0: return (i % 2 == 1) ? -1000 : 1000;
            1: return (i == 1800) ? 3000 : ((i == 1801) ? -2500 : 0);
            default: return -8192;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        msg = 14'sd500;
        repeat (3) tick();
        checks++;
        if (env !== 14'sd0 || dc !== 14'sd0 || busy !== 1'b0 || dc_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset: env=%0d dc=%0d busy=%b dc_valid=%b required all 0",
                     env, dc, busy, dc_valid);
        end
        msg = '0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_envelope(input string tag, input int v0, input int v1, input int v2);
        int v[3];
        int e;
        v[0] = v0;
        v[1] = v1;
        v[2] = v2;
        for (int i = 0; i < 3; i++) begin
            msg = v[i][13:0];
            env_q.push_back(sat14(v[i] + model_dc));
            tick();
            if (i > 0) begin
                e = env_q.pop_front();
                checks++;
                if (env !== e[13:0]) begin
                    errors++;
                    $display("FAIL env_%s[%0d]: got %0d required %0d", tag, i - 1, env, e);
                end
            end
        end
        tick();
        e = env_q.pop_front();
        checks++;
        if (env !== e[13:0]) begin
            errors++;
            $display("FAIL env_%s[2]: got %0d required %0d", tag, env, e);
        end
        checks++;
        if (busy !== 1'b0 || dc_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_%s: busy=%b dc_valid=%b required 0 0", tag, busy, dc_valid);
        end
        msg = '0;
    endtask

    task automatic test_cal_ignored();
        int seen = 0;
        depth = 8'd128;
        cal_trig = 1'b1;
        tick();
        cal_trig = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL cal_no_peak_busy: got %b required 0", busy);
        end
        for (int k = 0; k < 30; k++) begin
            tick();
            if (dc_valid === 1'b1 || busy === 1'b1) seen = 1;
        end
        checks++;
        if (seen != 0 || dc !== 14'sd0) begin
            errors++;
            $display("FAIL cal_no_peak: activity=%0d dc=%0d required 0 0", seen, dc);
        end
    endtask

    task automatic test_measure(input string tag, input int mode, input bit both, input bit cal_mid);
        int n = 0;
        int seen = 0;
        int pk = 0;
        for (int i = 0; i < 3600; i++)
            if (abs_sat(pattern(mode, i)) > pk) pk = abs_sat(pattern(mode, i));
        msg = pattern(mode, 0);
        depth = 8'd128;
        meas_trig = 1'b1;
        cal_trig = both;
        tick();
        meas_trig = 1'b0;
        cal_trig = 1'b0;
        if (busy === 1'b1) n = 1;
        for (int i = 1; i < 4000; i++) begin
            msg = pattern(mode, i);
            cal_trig = (cal_mid && i == 100);
            tick();
            if (dc_valid === 1'b1) seen = 1;
            if (busy !== 1'b1) break;
            n++;
        end
        cal_trig = 1'b0;
        msg = '0;
        checks++;
        if (n != 3600) begin
            errors++;
            $display("FAIL meas_len_%s: busy for %0d cycles required 3600", tag, n);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL meas_dcv_%s: dc_valid seen=%0d required 0", tag, seen);
        end
        model_peak = pk;
        tick();
    endtask

    task automatic test_calibrate(input string tag, input int d);
        int lat = 0;
        int e;
        dc_q.push_back(div_model(model_peak, d));
        depth = d[7:0];
        cal_trig = 1'b1;
        tick();
        cal_trig = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL cal_busy_%s: got %b required 1", tag, busy);
        end
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (dc_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        e = dc_q.pop_front();
        checks++;
        if (lat == 0) begin
            errors++;
            $display("FAIL cal_timeout_%s: no dc_valid within 40 cycles required at 22", tag);
        end else begin
            if (dc !== e[13:0]) begin
                errors++;
                $display("FAIL dc_%s: got %0d required %0d", tag, dc, e);
            end
            checks++;
            if (lat != 22) begin
                errors++;
                $display("FAIL cal_latency_%s: got %0d required 22", tag, lat);
            end
        end
        tick();
        checks++;
        if (dc_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cal_end_%s: dc_valid=%b busy=%b required 0 0", tag, dc_valid, busy);
        end
        model_dc = e;
    endtask

    task automatic test_reset_mid_div();
        int seen = 0;
        msg = 14'sd700;
        depth = 8'd128;
        cal_trig = 1'b1;
        tick();
        cal_trig = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (env !== 14'sd0 || dc !== 14'sd0 || busy !== 1'b0 || dc_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_div: env=%0d dc=%0d busy=%b dc_valid=%b required all 0",
                     env, dc, busy, dc_valid);
        end
        msg = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        env_q.delete();
        dc_q.delete();
        model_dc = 0;
        tick();
        cal_trig = 1'b1;
        tick();
        cal_trig = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (dc_valid === 1'b1 || busy === 1'b1) seen = 1;
        end
        checks++;
        if (seen != 0 || dc !== 14'sd0 || env !== 14'sd0) begin
            errors++;
            $display("FAIL reset_div_after: activity=%0d dc=%0d env=%0d required 0 0 0",
                     seen, dc, env);
        end
    endtask

    initial begin
        test_reset();
        test_envelope("pass", 500, -8192, 8191);
        test_cal_ignored();
        test_measure("alt", 0, 1'b0, 1'b1);
        test_calibrate("d128", 128);
        test_envelope("dc2000", -1000, 1000, -5000);
        test_calibrate("d255", 255);
        test_calibrate("d0", 0);
        test_envelope("sat", 1000, -8192, 0);
        test_measure("spike", 1, 1'b0, 1'b0);
        test_calibrate("spike", 128);
        test_envelope("dc6000", 3000, -7000, -8192);
        test_measure("full_both", 2, 1'b1, 1'b0);
        test_calibrate("d1", 1);
        test_reset_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/am_dc_injector.md
Name: am_dc_injector

Overview:
- Transmit-side counterpart of the demodulator's DC-removal path.
- Takes a signed AC baseband message, measures its peak magnitude over a fixed window, and computes the DC offset needed for a programmed modulation depth (DC = peak/m) with a sequential divider.
- Outputs the saturated envelope msg + DC, which feeds the AM multiplier/DAC path.
- Runs at the sample clock (1.8 MHz sample strobe = clk).

Parameters:
IO_width, 14, width of signed message/envelope/DC
CNT_WIDTH, 32, measurement counter width
CNT_NUM, 3600, samples per peak-measurement window (2 ms at 1.8 MHz)
DEPTH_W, 8, width of depth input (unsigned Q0.DEPTH_W)

Ports:
clk  in  1  system clock, one sample per cycle
rst_n  in  1  asynchronous active-low reset
meas_trig  in  1  start peak measurement (sampled in IDLE)
cal_trig  in  1  start DC calculation (sampled in IDLE)
depth  in  DEPTH_W  modulation depth m = depth/2^DEPTH_W, unsigned
msg  in  IO_width  signed AC message
env  out  IO_width  signed envelope = sat(msg + dc)
dc  out  IO_width  signed current DC offset, always >= 0
busy  out  1  high in MEAS or DIV
dc_valid  out  1  one-cycle pulse when dc updates

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: env=0, dc=0, busy=0, dc_valid=0, peak=0, peak_valid=0, state=IDLE. Reset mid-MEAS or mid-DIV aborts the operation, and dc returns to 0.
- Datapath latency:
  - msg is registered into msg_r.
  - env <= sat(msg_r + dc), computed in IO_width+1 bits and clamped to [-2^(IO_width-1), 2^(IO_width-1)-1].
  - Total latency msg->env is 2 cycles.
  - env always uses the current dc register; this path is independent of the FSM.
- FSM states: IDLE, MEAS, DIV.
- IDLE:
  - If meas_trig=1 -> MEAS: clear peak, cnt=0.
  - Else if cal_trig=1 and peak_valid=1 -> DIV.
  - If meas_trig and cal_trig are both high, meas_trig wins.
  - cal_trig with peak_valid=0 is ignored.
- MEAS:
  - Each cycle, peak <= max(peak, |msg_r|). |most negative value| saturates to 2^(IO_width-1)-1.
  - cnt increments each cycle. When cnt reaches CNT_NUM-1, set peak_valid=1 and return to IDLE.
  - meas_trig sampled at edge N gives samples at edges N+1..N+CNT_NUM.
- DIV:
  - Unsigned restoring divide, one quotient bit per cycle. Numerator = peak << DEPTH_W (IO_width-1+DEPTH_W bits); divisor = depth, latched at entry.
  - For cal_trig sampled at edge N:
    - iterations run on edges N+1..N+IO_width-1+DEPTH_W;
    - dc registered and dc_valid pulsed at edge N+IO_width+DEPTH_W (22 for defaults);
    - the FSM then returns to IDLE.
  - Quotient is floor, clamped to 2^(IO_width-1)-1.
  - If depth==0, dc = 2^(IO_width-1)-1 with the same latency.
- Trigger handling: triggers while busy=1 are ignored, not queued. dc holds its value between calibrations. peak_valid stays set until a new MEAS starts, where it clears.

Test Plan:
1. Reset, then msg=500 -> env=500 two cycles after msg applied; dc=0, busy=0, dc_valid=0.
2. meas_trig with msg alternating +/-1000 for 3600 cycles, then cal_trig, depth=128 -> dc_valid pulse exactly 22 cycles after cal_trig, dc=2000.
   - Then msg=-1000 -> env=1000; msg=+1000 -> env=3000.
3. peak=1000, depth=255 -> dc=1003 (floor).
   - depth=0 -> dc=8191.
   - msg=1000 with dc=8191 -> env=8191 (saturated).
4. msg=-8192 during MEAS -> peak=8191; depth=256-scale limit: depth=1 -> dc clamps to 8191.
5. Trigger edge cases:
   - cal_trig before any measurement -> ignored, dc stays 0.
   - meas_trig and cal_trig in the same cycle -> MEAS entered.
   - cal_trig pulsed during MEAS -> ignored.
6. Assert rst_n low at cycle 10 of DIV -> all outputs 0 immediately; after release, state IDLE, no dc_valid pulse.
